windowed_reg_file: RTL and testbench
====================================

// Module: windowed_reg_file
// PURPOSE
//  Parametrised register-window file for the multi-cycle/single-cycle CPU datapath. Holds
//  NUM_WIN*WIN_STRIDE physical registers, of which WIN_REGS are visible through the current
//  window pointer (cwp); adjacent windows overlap by WIN_REGS-WIN_STRIDE registers.
//  Supports call/return window moves with nesting-depth tracking and overflow/underflow flags.
// PARAMETERS
//  DATA_W      16  register width in bits
//  NUM_WIN     4   number of windows (power of 2, >=2)
//  WIN_REGS    4   registers visible per window (power of 2)
//  WIN_STRIDE  2   physical offset between consecutive windows (1..WIN_REGS)
//  localparams: PHYS = NUM_WIN*WIN_STRIDE, AW = clog2(WIN_REGS), WW = clog2(NUM_WIN), PW = clog2(PHYS)
// PORTS
//  clk           in   1       clock, all state updates on posedge
//  rst           in   1       asynchronous active-high reset
//  rd_addr_i     in   AW      logical read address, port i
//  rd_addr_j     in   AW      logical read address, port j
//  rd_data_i     out  DATA_W  read data, port i (combinational)
//  rd_data_j     out  DATA_W  read data, port j (combinational)
//  wr_en         in   1       write enable
//  wr_addr       in   AW      logical write address
//  wr_data       in   DATA_W  write data
//  win_op        in   2       00 HOLD, 01 SET, 10 CALL, 11 RET
//  win_set_val   in   WW      target window for SET
//  cwp           out  WW      current window pointer (registered)
//  depth         out  WW      current call nesting depth (registered)
//  win_overflow  out  1       one-cycle pulse: CALL refused
//  win_underflow out  1       one-cycle pulse: RET refused
// BEHAVIOUR
//  - Reset: all PHYS registers = 0, cwp = 0, depth = 0, win_overflow = win_underflow = 0.
//  - Physical index phys(a) = (cwp*WIN_STRIDE + a) mod PHYS; wrap is modular, never out of range.
//  - Reads: rd_data_x = mem[phys(rd_addr_x)] combinationally, using current cwp; no write bypass
//    (a same-cycle write is visible only after the edge).
//  - Write: on posedge with wr_en=1, mem[phys(wr_addr)] <= wr_data using cwp BEFORE any window
//    op in the same cycle.
//  - Window ops (posedge, evaluated in order of priority: SET > CALL > RET; one op per cycle):
//    SET : cwp <= win_set_val; depth <= 0; no flags.
//    CALL: if depth < NUM_WIN-1: cwp <= cwp+1 (mod NUM_WIN), depth <= depth+1;
//          else no change, win_overflow <= 1 for exactly one cycle.
//    RET : if depth > 0: cwp <= cwp-1 (mod NUM_WIN), depth <= depth-1;
//          else no change, win_underflow <= 1 for exactly one cycle.
//    HOLD: no change. Flags deassert on any cycle without a refused op.
//  - Latency: cwp/depth/flags change 1 cycle after the op; reads re-point immediately after.
//  - Overlap: register WIN_STRIDE+k of window w aliases register k of window w+1 (args passing).
//  - rst asserted mid-operation overrides everything asynchronously; pending write is lost.
// STRUCTURE
//  - Package windowed_rf_pkg: win_op_t enum {WIN_HOLD, WIN_SET, WIN_CALL, WIN_RET} (2-bit),
//    shared by the control unit driving win_op.
//  - Sub-module window_ctrl: cwp/depth registers, op decode, overflow/underflow pulses.
//    Top level holds storage array, index arithmetic, read muxes and write decode.
// TESTING (defaults: DATA_W=16, NUM_WIN=4, WIN_REGS=4, WIN_STRIDE=2)
//  1 Reset: assert rst mid-run -> all reads 0, cwp=0, depth=0, flags 0 immediately.
//  2 Overlap: cwp=0 write r2=16'hAAAA, r3=16'hBBBB; CALL -> cwp=1, read r0=AAAA, r1=BBBB.
//  3 Overflow: 3 CALLs -> depth=3, cwp=3; 4th CALL -> win_overflow pulses 1 cycle, cwp stays 3.
//  4 Wrap: SET 3, write r2=16'h1234 -> phys 0; SET 0, read r0 = 1234.
//  5 Underflow: after reset RET -> win_underflow 1 cycle, cwp=0; CALL then RET -> cwp=0, no flag.
//  6 Same-cycle: cwp=0, wr_en r2=16'h00FF with CALL -> phys 2 written; next cycle r0 reads 00FF.

Source files
------------

// File: rtl/windowed_rf_pkg.sv
// Shared types for the register-window file and the control unit that drives it.
package windowed_rf_pkg;

  typedef enum logic [1:0] {
    WIN_HOLD = 2'b00,
    WIN_SET  = 2'b01,
    WIN_CALL = 2'b10,
    WIN_RET  = 2'b11
  } win_op_t;

endpackage

// File: rtl/window_ctrl.sv
// Window pointer and nesting-depth tracking, with one-cycle pulses for
// refused calls and returns.
module window_ctrl
  import windowed_rf_pkg::*;
#(
  parameter int unsigned NUM_WIN = 4,
  parameter int unsigned WW      = $clog2(NUM_WIN)
) (
  input  logic          clk,
  input  logic          rst,
  input  win_op_t       win_op_i,
  input  logic [WW-1:0] win_set_val_i,
  output logic [WW-1:0] cwp_o,
  output logic [WW-1:0] depth_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  localparam logic [WW-1:0] MaxDepth = WW'(NUM_WIN - 1);

  logic [WW-1:0] cwp_q, cwp_d;
  logic [WW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cwp_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      cwp_q   <= cwp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // The pointer wraps modulo NUM_WIN for free because NUM_WIN is a power of 2.
  always_comb begin
    cwp_d   = cwp_q;
    depth_d = depth_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    case (win_op_i)
      WIN_SET: begin
        cwp_d   = win_set_val_i;
        depth_d = '0;
      end
      WIN_CALL: begin
        if (depth_q < MaxDepth) begin
          cwp_d   = cwp_q + WW'(1);
          depth_d = depth_q + WW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      WIN_RET: begin
        if (depth_q != '0) begin
          cwp_d   = cwp_q - WW'(1);
          depth_d = depth_q - WW'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign cwp_o       = cwp_q;
  assign depth_o     = depth_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: rtl/windowed_reg_file.sv
// Register-window file: physical storage, logical-to-physical mapping through
// the current window pointer, two combinational read ports and one write port.
module windowed_reg_file
  import windowed_rf_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_WIN    = 4,
  parameter int unsigned WIN_REGS   = 4,
  parameter int unsigned WIN_STRIDE = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(WIN_REGS)-1:0]  rd_addr_i,
  input  logic [$clog2(WIN_REGS)-1:0]  rd_addr_j,
  output logic [DATA_W-1:0]            rd_data_i,
  output logic [DATA_W-1:0]            rd_data_j,
  input  logic                         wr_en,
  input  logic [$clog2(WIN_REGS)-1:0]  wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  win_op_t                      win_op,
  input  logic [$clog2(NUM_WIN)-1:0]   win_set_val,
  output logic [$clog2(NUM_WIN)-1:0]   cwp,
  output logic [$clog2(NUM_WIN)-1:0]   depth,
  output logic                         win_overflow,
  output logic                         win_underflow
);

  localparam int unsigned PHYS = NUM_WIN * WIN_STRIDE;
  localparam int unsigned AW   = $clog2(WIN_REGS);
  localparam int unsigned WW   = $clog2(NUM_WIN);
  localparam int unsigned PW   = $clog2(PHYS);
  // Wide enough for cwp*WIN_STRIDE + a before the modular reduction.
  localparam int unsigned SW   = $clog2(PHYS + WIN_REGS);

  logic [DATA_W-1:0] mem_q [PHYS];
  logic [SW-1:0]     base;
  logic [PW-1:0]     rd_idx_i, rd_idx_j, wr_idx;

  window_ctrl #(
    .NUM_WIN (NUM_WIN),
    .WW      (WW)
  ) u_window_ctrl (
    .clk           (clk),
    .rst           (rst),
    .win_op_i      (win_op),
    .win_set_val_i (win_set_val),
    .cwp_o         (cwp),
    .depth_o       (depth),
    .overflow_o    (win_overflow),
    .underflow_o   (win_underflow)
  );

  function automatic logic [PW-1:0] phys_idx(input logic [SW-1:0] b, input logic [AW-1:0] a);
    logic [SW-1:0] sum;
    sum = b + SW'(a);
    return PW'(sum % SW'(PHYS));
  endfunction

  assign base     = SW'(cwp) * SW'(WIN_STRIDE);
  assign rd_idx_i = phys_idx(base, rd_addr_i);
  assign rd_idx_j = phys_idx(base, rd_addr_j);
  assign wr_idx   = phys_idx(base, wr_addr);

  // No bypass: a write becomes visible to the read ports only after the edge.
  assign rd_data_i = mem_q[rd_idx_i];
  assign rd_data_j = mem_q[rd_idx_j];

  // Write index uses the pre-op cwp, so a write alongside CALL lands in the caller's window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(PHYS); k++) begin
        mem_q[k] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_windowed_reg_file.sv
// Directed bench for windowed_reg_file at default parameters.
module tb_windowed_reg_file;
  import windowed_rf_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  rd_addr_i, rd_addr_j, wr_addr;
  logic [15:0] rd_data_i, rd_data_j, wr_data;
  logic        wr_en;
  win_op_t     win_op;
  logic [1:0]  win_set_val;
  logic [1:0]  cwp, depth;
  logic        win_overflow, win_underflow;

  int total = 0;
  int bad   = 0;

  windowed_reg_file dut (
    .clk           (clk),
    .rst           (rst),
    .rd_addr_i     (rd_addr_i),
    .rd_addr_j     (rd_addr_j),
    .rd_data_i     (rd_data_i),
    .rd_data_j     (rd_data_j),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .win_op        (win_op),
    .win_set_val   (win_set_val),
    .cwp           (cwp),
    .depth         (depth),
    .win_overflow  (win_overflow),
    .win_underflow (win_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    win_op = WIN_HOLD;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
  endtask

  task automatic do_op(input win_op_t op, input logic [1:0] v);
    win_op = op; win_set_val = v;
    step();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (cwp !== 2'd0 || depth !== 2'd0 || win_overflow !== 1'b0 || win_underflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_init: cwp=%0d depth=%0d ovf=%b unf=%b, want 0 0 0 0", cwp, depth, win_overflow, win_underflow);
    end
    rst = 1'b0;
    do_write(2'd1, 16'h5555);
    do_op(WIN_CALL, 2'd0);
    total++;
    if (cwp !== 2'd1 || depth !== 2'd1) begin
      bad++;
      $display("FAIL reset_prerun: cwp=%0d depth=%0d, want 1 1", cwp, depth);
    end
    // pending write queued, then asynchronous reset mid-cycle
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'h9999;
    #2;
    rst = 1'b1;
    rd_addr_i = 2'd0; rd_addr_j = 2'd1;
    #1;
    total++;
    if (cwp !== 2'd0 || depth !== 2'd0 || win_overflow !== 1'b0 || win_underflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_async_ctrl: cwp=%0d depth=%0d ovf=%b unf=%b, want 0 0 0 0", cwp, depth, win_overflow, win_underflow);
    end
    total++;
    if (rd_data_i !== 16'h0000 || rd_data_j !== 16'h0000) begin
      bad++;
      $display("FAIL reset_async_mem: r0=%h r1=%h, want 0000 0000", rd_data_i, rd_data_j);
    end
    step();
    rst = 1'b0;
    #1;
    total++;
    if (rd_data_i !== 16'h0000) begin
      bad++;
      $display("FAIL reset_lost_write: r0=%h, want 0000", rd_data_i);
    end
  endtask

  task automatic test_overlap();
    do_reset();
    do_write(2'd2, 16'hAAAA);
    do_write(2'd3, 16'hBBBB);
    do_op(WIN_CALL, 2'd0);
    rd_addr_i = 2'd0; rd_addr_j = 2'd1;
    #1;
    total++;
    if (cwp !== 2'd1 || depth !== 2'd1) begin
      bad++;
      $display("FAIL overlap_cwp: cwp=%0d depth=%0d, want 1 1", cwp, depth);
    end
    total++;
    if (rd_data_i !== 16'hAAAA || rd_data_j !== 16'hBBBB) begin
      bad++;
      $display("FAIL overlap_read: r0=%h r1=%h, want aaaa bbbb", rd_data_i, rd_data_j);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int n = 1; n <= 3; n++) begin
      do_op(WIN_CALL, 2'd0);
      total++;
      if (cwp !== 2'(n) || depth !== 2'(n) || win_overflow !== 1'b0) begin
        bad++;
        $display("FAIL overflow_call%0d: cwp=%0d depth=%0d ovf=%b, want %0d %0d 0", n, cwp, depth, win_overflow, n, n);
      end
    end
    do_op(WIN_CALL, 2'd0);
    total++;
    if (win_overflow !== 1'b1 || cwp !== 2'd3 || depth !== 2'd3) begin
      bad++;
      $display("FAIL overflow_refused: ovf=%b cwp=%0d depth=%0d, want 1 3 3", win_overflow, cwp, depth);
    end
    step();
    total++;
    if (win_overflow !== 1'b0 || cwp !== 2'd3) begin
      bad++;
      $display("FAIL overflow_pulse: ovf=%b cwp=%0d, want 0 3", win_overflow, cwp);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    do_op(WIN_SET, 2'd3);
    total++;
    if (cwp !== 2'd3 || depth !== 2'd0) begin
      bad++;
      $display("FAIL wrap_set: cwp=%0d depth=%0d, want 3 0", cwp, depth);
    end
    do_write(2'd2, 16'h1234);
    do_op(WIN_SET, 2'd0);
    rd_addr_i = 2'd0; rd_addr_j = 2'd2;
    #1;
    total++;
    if (rd_data_i !== 16'h1234 || rd_data_j !== 16'h0000) begin
      bad++;
      $display("FAIL wrap_read: r0=%h r2=%h, want 1234 0000", rd_data_i, rd_data_j);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    do_op(WIN_RET, 2'd0);
    total++;
    if (win_underflow !== 1'b1 || cwp !== 2'd0 || depth !== 2'd0) begin
      bad++;
      $display("FAIL underflow_refused: unf=%b cwp=%0d depth=%0d, want 1 0 0", win_underflow, cwp, depth);
    end
    step();
    total++;
    if (win_underflow !== 1'b0) begin
      bad++;
      $display("FAIL underflow_pulse: unf=%b, want 0", win_underflow);
    end
    do_op(WIN_CALL, 2'd0);
    do_op(WIN_RET, 2'd0);
    total++;
    if (cwp !== 2'd0 || depth !== 2'd0 || win_underflow !== 1'b0) begin
      bad++;
      $display("FAIL underflow_callret: cwp=%0d depth=%0d unf=%b, want 0 0 0", cwp, depth, win_underflow);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'h00FF;
    win_op = WIN_CALL;
    rd_addr_i = 2'd2; rd_addr_j = 2'd0;
    #1;
    total++;
    if (rd_data_i !== 16'h0000) begin
      bad++;
      $display("FAIL same_no_bypass: r2=%h, want 0000", rd_data_i);
    end
    step();
    rd_addr_i = 2'd0;
    #1;
    total++;
    if (cwp !== 2'd1 || rd_data_i !== 16'h00FF) begin
      bad++;
      $display("FAIL same_cycle: cwp=%0d r0=%h, want 1 00ff", cwp, rd_data_i);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_op(WIN_SET, 2'd2);
    do_op(WIN_CALL, 2'd0);
    total++;
    if (cwp !== 2'd3 || depth !== 2'd1) begin
      bad++;
      $display("FAIL b2b_call: cwp=%0d depth=%0d, want 3 1", cwp, depth);
    end
    do_op(WIN_CALL, 2'd0);
    total++;
    if (cwp !== 2'd0 || depth !== 2'd2) begin
      bad++;
      $display("FAIL b2b_wrap: cwp=%0d depth=%0d, want 0 2", cwp, depth);
    end
    do_op(WIN_RET, 2'd0);
    do_op(WIN_RET, 2'd0);
    total++;
    if (cwp !== 2'd2 || depth !== 2'd0 || win_underflow !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ret: cwp=%0d depth=%0d unf=%b, want 2 0 0", cwp, depth, win_underflow);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_i = '0; rd_addr_j = '0; win_op = WIN_HOLD; win_set_val = '0;
    test_reset();
    test_overlap();
    test_overflow();
    test_wrap();
    test_underflow();
    test_same_cycle();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
